noc_wr_mem_target: RTL and testbench
====================================

NOC_WR_MEM_TARGET -- requirements
Module: noc_wr_mem_target

Interface
REQ-001 Parameters: SRC_X, default 0, this node's X coordinate; SRC_Y, default 0, this node's Y coordinate; FBITS, default 0, this node's fbits, placed in the ack's src_fbits.
REQ-002 Ports: clk  in  1  sole clock; rst_n  in  1  asynchronous active-low reset.
REQ-003 Ports: noc0_wr_tgt_req_val  in  1, noc0_wr_tgt_req_data  in  NOC_DATA_WIDTH, wr_tgt_noc0_req_rdy  out  1  inbound STORE_MEM header and payload flits.
REQ-004 Ports: wr_tgt_noc0_resp_val  out  1, wr_tgt_noc0_resp_data  out  NOC_DATA_WIDTH, noc0_wr_tgt_resp_rdy  in  1  outbound ack header flit.
REQ-005 Ports: wr_tgt_mem_req_val  out  1, wr_tgt_mem_req_entry  out  mem_req_struct (addr, size), mem_wr_tgt_req_rdy  in  1  memory write command.
REQ-006 Ports: wr_tgt_mem_data_val  out  1, wr_tgt_mem_data  out  NOC_DATA_WIDTH, wr_tgt_mem_data_last  out  1, wr_tgt_mem_data_padbytes  out  NOC_PADBYTES_WIDTH, mem_wr_tgt_data_rdy  in  1  memory write payload.
REQ-007 Ports: mem_wr_tgt_done  in  1  one-cycle pulse: memory committed the write; wr_tgt_err  out  1  sticky protocol error (macro only, else tied 0).

Function
REQ-008 All handshakes SHALL transfer on val&rdy in the same cycle; val SHALL NOT depend combinationally on the same interface's rdy.
REQ-009 FSM states SHALL be IDLE, ISSUE_REQ, PASS_DATA, WAIT_MEM_DONE, SEND_ACK, DRAIN.
REQ-010 IDLE: req_rdy=1; a header flit SHALL be registered (addr, data_size, msg_len, src chip/x/y, src_fbits); next state ISSUE_REQ.
REQ-011 ISSUE_REQ: mem_req_val=1 with entry {addr, data_size}; on mem_req_rdy go to PASS_DATA, or to WAIT_MEM_DONE if msg_len==0.
REQ-012 PASS_DATA: flits pass combinationally: mem_data_val=noc0 req val, req_rdy=mem_data_rdy, data unchanged; a counter SHALL increment per transfer.
REQ-013 data_last SHALL be 1 exactly when count==msg_len-1; padbytes SHALL be (msg_len*NOC_DATA_BYTES - data_size) on the last flit, 0 otherwise, truncated to NOC_PADBYTES_WIDTH.
REQ-014 Transfer of the last flit SHALL move to WAIT_MEM_DONE.
REQ-015 WAIT_MEM_DONE: all rdy/val low; on mem_wr_tgt_done go to SEND_ACK. A done pulse seen in any other state SHALL be ignored.
REQ-016 SEND_ACK: resp_val=1, ack header: dst chip/x/y=registered src, dst fbits=registered src_fbits, msg_len=0, msg_type=MSG_TYPE_STORE_MEM_ACK, src_x/y=SRC_X/SRC_Y, src_fbits=FBITS, all else 0.
REQ-017 SEND_ACK: on resp_rdy go to IDLE; the next header is not accepted in that cycle (one bubble minimum).
REQ-018 Min latency header-accept to ack-valid: 3 cycles plus payload flits plus memory done latency.
REQ-019 Counter width SHALL be MSG_LENGTH_WIDTH; msg_len at maximum SHALL NOT wrap before last.
REQ-020 Illegal state SHALL drive all outputs and next state to X (simulation only).

Reset
REQ-021 On rst_n low, asynchronously: state=IDLE, registered header=0, counter=0, wr_tgt_err=0.
REQ-022 During reset all val/rdy outputs SHALL be 0; a transfer in flight when reset asserts is dropped, no ack sent.
REQ-023 After rst_n deasserts, the first header SHALL be accepted in the first cycle with req_val=1.

Configuration
REQ-024 Macro NOC_WR_TGT_TYPE_CHECK_EN.
REQ-025 Defined: a header with msg_type!=MSG_TYPE_STORE_MEM SHALL set wr_tgt_err (sticky until reset), enter DRAIN, consume msg_len payload flits with req_rdy=1 and no memory activity, then return to IDLE with no ack.
REQ-026 Not defined: msg_type is not inspected; every header is treated as STORE_MEM; wr_tgt_err tied 0; DRAIN unreachable.

Verification (NOC_DATA_BYTES=64)
REQ-027 Header addr=0x1000, size=128, msg_len=2, src (3,1) -> one mem req {0x1000,128}, 2 data flits, last on 2nd, padbytes=0, ack to (3,1) after done.
REQ-028 size=100, msg_len=2 -> second flit last=1, padbytes=28; first flit padbytes=0.
REQ-029 msg_len=0, size=0 -> mem req issued, no data flits, ack after done pulse.
REQ-030 Random backpressure on mem_data_rdy and resp_rdy (50%) over 100 writes -> data order and counts preserved, exactly 100 acks.
REQ-031 Macro on, msg_type=LOAD_MEM, msg_len=3 -> 3 flits drained, no mem req, no ack, wr_tgt_err=1 until reset.
REQ-032 rst_n asserted mid-PASS_DATA after 1 of 4 flits -> outputs 0 immediately, IDLE; next header processed normally.

Source files
------------

// File: rtl/noc_wr_mem_target.sv
// noc_wr_mem_target: turns NoC STORE_MEM writes into a memory write command, streams the payload, and returns a STORE_MEM_ACK.
// Latency: from header accept to ack valid is 3 cycles + payload flits + memory done latency; one write in flight at a time.
// Backpressure: payload flits stall on mem_wr_tgt_data_rdy. Building with NOC_WR_TGT_TYPE_CHECK_EN drains non-STORE_MEM messages and flags them.

package noc_wr_pkg;
    localparam int NOC_DATA_WIDTH     = 512;
    localparam int NOC_DATA_BYTES     = NOC_DATA_WIDTH / 8;
    localparam int NOC_PADBYTES_WIDTH = 6;
    localparam int MSG_LENGTH_WIDTH   = 8;
    localparam int MSG_TYPE_WIDTH     = 8;
    localparam int CHIP_WIDTH         = 14;
    localparam int COORD_WIDTH        = 8;
    localparam int FBITS_WIDTH        = 4;
    localparam int ADDR_WIDTH         = 48;
    localparam int DATA_SIZE_WIDTH    = 16;
    localparam int HDR_USED_WIDTH     = 2 * (CHIP_WIDTH + 2 * COORD_WIDTH + FBITS_WIDTH)
                                      + MSG_LENGTH_WIDTH + MSG_TYPE_WIDTH + ADDR_WIDTH + DATA_SIZE_WIDTH;

    localparam logic [MSG_TYPE_WIDTH-1:0] MSG_TYPE_LOAD_MEM      = 8'd19;
    localparam logic [MSG_TYPE_WIDTH-1:0] MSG_TYPE_STORE_MEM     = 8'd20;
    localparam logic [MSG_TYPE_WIDTH-1:0] MSG_TYPE_STORE_MEM_ACK = 8'd24;

    typedef struct packed {
        logic [CHIP_WIDTH-1:0]                     dst_chip;
        logic [COORD_WIDTH-1:0]                    dst_x;
        logic [COORD_WIDTH-1:0]                    dst_y;
        logic [FBITS_WIDTH-1:0]                    dst_fbits;
        logic [MSG_LENGTH_WIDTH-1:0]               msg_len;
        logic [MSG_TYPE_WIDTH-1:0]                 msg_type;
        logic [CHIP_WIDTH-1:0]                     src_chip;
        logic [COORD_WIDTH-1:0]                    src_x;
        logic [COORD_WIDTH-1:0]                    src_y;
        logic [FBITS_WIDTH-1:0]                    src_fbits;
        logic [ADDR_WIDTH-1:0]                     addr;
        logic [DATA_SIZE_WIDTH-1:0]                data_size;
        logic [NOC_DATA_WIDTH-HDR_USED_WIDTH-1:0]  rsvd;
    } hdr_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]      addr;
        logic [DATA_SIZE_WIDTH-1:0] size;
    } mem_req_struct;
endpackage

module noc_wr_mem_target
    import noc_wr_pkg::*;
#(
    parameter logic [COORD_WIDTH-1:0] SRC_X = '0,
    parameter logic [COORD_WIDTH-1:0] SRC_Y = '0,
    parameter logic [FBITS_WIDTH-1:0] FBITS = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          noc0_wr_tgt_req_val,
    input  logic [NOC_DATA_WIDTH-1:0]     noc0_wr_tgt_req_data,
    output logic                          wr_tgt_noc0_req_rdy,
    output logic                          wr_tgt_noc0_resp_val,
    output logic [NOC_DATA_WIDTH-1:0]     wr_tgt_noc0_resp_data,
    input  logic                          noc0_wr_tgt_resp_rdy,
    output logic                          wr_tgt_mem_req_val,
    output mem_req_struct                 wr_tgt_mem_req_entry,
    input  logic                          mem_wr_tgt_req_rdy,
    output logic                          wr_tgt_mem_data_val,
    output logic [NOC_DATA_WIDTH-1:0]     wr_tgt_mem_data,
    output logic                          wr_tgt_mem_data_last,
    output logic [NOC_PADBYTES_WIDTH-1:0] wr_tgt_mem_data_padbytes,
    input  logic                          mem_wr_tgt_data_rdy,
    input  logic                          mem_wr_tgt_done,
    output logic                          wr_tgt_err
);

    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        ISSUE_REQ     = 3'd1,
        PASS_DATA     = 3'd2,
        WAIT_MEM_DONE = 3'd3,
        SEND_ACK      = 3'd4,
        DRAIN         = 3'd5
    } state_t;

    state_t                       state, state_nxt;
    hdr_t                         in_hdr;
    hdr_t                         ack_hdr;
    logic [ADDR_WIDTH-1:0]        addr_q;
    logic [DATA_SIZE_WIDTH-1:0]   size_q;
    logic [MSG_LENGTH_WIDTH-1:0]  len_q;
    logic [CHIP_WIDTH-1:0]        src_chip_q;
    logic [COORD_WIDTH-1:0]       src_x_q;
    logic [COORD_WIDTH-1:0]       src_y_q;
    logic [FBITS_WIDTH-1:0]       src_fbits_q;
    logic [MSG_LENGTH_WIDTH-1:0]  cnt_q;
    logic                         is_last;
    logic [NOC_PADBYTES_WIDTH-1:0] pad_last;
    logic                         type_bad;
    logic                         hdr_take;
    logic                         flit_take;
    logic                         err_set;
    logic                         unused_hdr_bits;

    assign in_hdr = hdr_t'(noc0_wr_tgt_req_data);

    // Destination-side header fields and reserved bits are never needed here.
    assign unused_hdr_bits = ^{in_hdr.dst_chip, in_hdr.dst_x, in_hdr.dst_y, in_hdr.dst_fbits,
                               in_hdr.msg_type, in_hdr.rsvd, err_set};

`ifdef NOC_WR_TGT_TYPE_CHECK_EN
    assign type_bad = (in_hdr.msg_type != MSG_TYPE_STORE_MEM);
`else
    assign type_bad = 1'b0;
`endif

    // Counter compares against msg_len-1, so msg_len at its maximum ends at all-ones-minus-one and never wraps.
    assign is_last  = (cnt_q == (len_q - MSG_LENGTH_WIDTH'(1)));
    assign pad_last = NOC_PADBYTES_WIDTH'(DATA_SIZE_WIDTH'(len_q) * DATA_SIZE_WIDTH'(NOC_DATA_BYTES) - size_q);

    // Ack header is built purely from the captured request source and this node's identity.
    always_comb begin
        ack_hdr           = '0;
        ack_hdr.dst_chip  = src_chip_q;
        ack_hdr.dst_x     = src_x_q;
        ack_hdr.dst_y     = src_y_q;
        ack_hdr.dst_fbits = src_fbits_q;
        ack_hdr.msg_len   = '0;
        ack_hdr.msg_type  = MSG_TYPE_STORE_MEM_ACK;
        ack_hdr.src_x     = SRC_X;
        ack_hdr.src_y     = SRC_Y;
        ack_hdr.src_fbits = FBITS;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; req_rdy is gated by rst_n so nothing is accepted while reset is held.
    always_comb begin
        state_nxt                = state;
        wr_tgt_noc0_req_rdy      = 1'b0;
        wr_tgt_noc0_resp_val     = 1'b0;
        wr_tgt_noc0_resp_data    = ack_hdr;
        wr_tgt_mem_req_val       = 1'b0;
        wr_tgt_mem_data_val      = 1'b0;
        wr_tgt_mem_data          = noc0_wr_tgt_req_data;
        wr_tgt_mem_data_last     = 1'b0;
        wr_tgt_mem_data_padbytes = '0;
        hdr_take                 = 1'b0;
        flit_take                = 1'b0;
        err_set                  = 1'b0;
        unique case (state)
            IDLE: begin
                wr_tgt_noc0_req_rdy = rst_n;
                if (noc0_wr_tgt_req_val) begin
                    hdr_take = 1'b1;
                    if (type_bad) begin
                        err_set   = 1'b1;
                        state_nxt = (in_hdr.msg_len == '0) ? IDLE : DRAIN;
                    end else begin
                        state_nxt = ISSUE_REQ;
                    end
                end
            end
            ISSUE_REQ: begin
                wr_tgt_mem_req_val = 1'b1;
                if (mem_wr_tgt_req_rdy) begin
                    state_nxt = (len_q == '0) ? WAIT_MEM_DONE : PASS_DATA;
                end
            end
            PASS_DATA: begin
                wr_tgt_mem_data_val      = noc0_wr_tgt_req_val;
                wr_tgt_noc0_req_rdy      = mem_wr_tgt_data_rdy;
                wr_tgt_mem_data_last     = is_last;
                wr_tgt_mem_data_padbytes = is_last ? pad_last : '0;
                if (noc0_wr_tgt_req_val && mem_wr_tgt_data_rdy) begin
                    flit_take = 1'b1;
                    if (is_last) begin
                        state_nxt = WAIT_MEM_DONE;
                    end
                end
            end
            WAIT_MEM_DONE: begin
                if (mem_wr_tgt_done) begin
                    state_nxt = SEND_ACK;
                end
            end
            SEND_ACK: begin
                wr_tgt_noc0_resp_val = 1'b1;
                if (noc0_wr_tgt_resp_rdy) begin
                    state_nxt = IDLE;
                end
            end
            DRAIN: begin
                wr_tgt_noc0_req_rdy = 1'b1;
                if (noc0_wr_tgt_req_val) begin
                    flit_take = 1'b1;
                    if (is_last) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt                = state_t'(3'bxxx);
                wr_tgt_noc0_req_rdy      = 1'bx;
                wr_tgt_noc0_resp_val     = 1'bx;
                wr_tgt_noc0_resp_data    = 'x;
                wr_tgt_mem_req_val       = 1'bx;
                wr_tgt_mem_data_val      = 1'bx;
                wr_tgt_mem_data          = 'x;
                wr_tgt_mem_data_last     = 1'bx;
                wr_tgt_mem_data_padbytes = 'x;
                hdr_take                 = 1'bx;
                flit_take                = 1'bx;
                err_set                  = 1'bx;
            end
        endcase
    end

    // Capture the header fields needed for the memory command, length tracking and the ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            size_q      <= '0;
            len_q       <= '0;
            src_chip_q  <= '0;
            src_x_q     <= '0;
            src_y_q     <= '0;
            src_fbits_q <= '0;
        end else if (hdr_take) begin
            addr_q      <= in_hdr.addr;
            size_q      <= in_hdr.data_size;
            len_q       <= in_hdr.msg_len;
            src_chip_q  <= in_hdr.src_chip;
            src_x_q     <= in_hdr.src_x;
            src_y_q     <= in_hdr.src_y;
            src_fbits_q <= in_hdr.src_fbits;
        end
    end

    // Payload flit counter, restarted by every header.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (hdr_take) begin
            cnt_q <= '0;
        end else if (flit_take) begin
            cnt_q <= cnt_q + MSG_LENGTH_WIDTH'(1);
        end
    end

    assign wr_tgt_mem_req_entry.addr = addr_q;
    assign wr_tgt_mem_req_entry.size = size_q;

`ifdef NOC_WR_TGT_TYPE_CHECK_EN
    logic err_q;

    // Sticky error: once a non-store header is seen it stays flagged until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign wr_tgt_err = err_q;
`else
    assign wr_tgt_err = 1'b0;
`endif

endmodule

// File: tb/tb_noc_wr_mem_target.sv
`timescale 1ns/1ps
module tb_noc_wr_mem_target;
    import noc_wr_pkg::*;

    localparam logic [7:0] TB_X = 8'd5;
    localparam logic [7:0] TB_Y = 8'd6;
    localparam logic [3:0] TB_F = 4'd2;

    logic                          clk = 1'b0;
    logic                          rst_n = 1'b1;
    logic                          noc0_wr_tgt_req_val = 1'b0;
    logic [NOC_DATA_WIDTH-1:0]     noc0_wr_tgt_req_data = '0;
    logic                          wr_tgt_noc0_req_rdy;
    logic                          wr_tgt_noc0_resp_val;
    logic [NOC_DATA_WIDTH-1:0]     wr_tgt_noc0_resp_data;
    logic                          noc0_wr_tgt_resp_rdy = 1'b0;
    logic                          wr_tgt_mem_req_val;
    mem_req_struct                 wr_tgt_mem_req_entry;
    logic                          mem_wr_tgt_req_rdy = 1'b0;
    logic                          wr_tgt_mem_data_val;
    logic [NOC_DATA_WIDTH-1:0]     wr_tgt_mem_data;
    logic                          wr_tgt_mem_data_last;
    logic [NOC_PADBYTES_WIDTH-1:0] wr_tgt_mem_data_padbytes;
    logic                          mem_wr_tgt_data_rdy = 1'b0;
    logic                          mem_wr_tgt_done = 1'b0;
    logic                          wr_tgt_err;

    always #5 clk = ~clk;

    noc_wr_mem_target #(.SRC_X(TB_X), .SRC_Y(TB_Y), .FBITS(TB_F)) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .noc0_wr_tgt_req_val      (noc0_wr_tgt_req_val),
        .noc0_wr_tgt_req_data     (noc0_wr_tgt_req_data),
        .wr_tgt_noc0_req_rdy      (wr_tgt_noc0_req_rdy),
        .wr_tgt_noc0_resp_val     (wr_tgt_noc0_resp_val),
        .wr_tgt_noc0_resp_data    (wr_tgt_noc0_resp_data),
        .noc0_wr_tgt_resp_rdy     (noc0_wr_tgt_resp_rdy),
        .wr_tgt_mem_req_val       (wr_tgt_mem_req_val),
        .wr_tgt_mem_req_entry     (wr_tgt_mem_req_entry),
        .mem_wr_tgt_req_rdy       (mem_wr_tgt_req_rdy),
        .wr_tgt_mem_data_val      (wr_tgt_mem_data_val),
        .wr_tgt_mem_data          (wr_tgt_mem_data),
        .wr_tgt_mem_data_last     (wr_tgt_mem_data_last),
        .wr_tgt_mem_data_padbytes (wr_tgt_mem_data_padbytes),
        .mem_wr_tgt_data_rdy      (mem_wr_tgt_data_rdy),
        .mem_wr_tgt_done          (mem_wr_tgt_done),
        .wr_tgt_err               (wr_tgt_err)
    );

    typedef struct {
        logic [NOC_DATA_WIDTH-1:0] dat;
        bit                        is_hdr;
    } src_t;

    typedef struct packed {
        logic [NOC_DATA_WIDTH-1:0] dat;
        logic                      last;
        logic [5:0]                pad;
    } flit_t;

    src_t                      src_q[$];
    mem_req_struct             exp_req_q[$];
    flit_t                     exp_flit_q[$];
    logic [NOC_DATA_WIDTH-1:0] exp_ack_q[$];
    int                        exp_len_q[$];

    int n_cmp = 0;
    int n_fail = 0;
    int bp = 0, done_max = 0, spur = 0;
    int cyc = 0, hdr_cyc = 0, last_ack_cyc = 0, last_lat = 0;
    int acks = 0, flits = 0, lasts = 0, reqs = 0;
    int cur_len = 0, seen = 0, done_cnt = -1;
    bit in_wr = 0, done_given = 0;
    logic [5:0]                last_pad = '0;
    logic [NOC_DATA_WIDTH-1:0] last_ack = '0;

    task automatic check(input string name, input logic [519:0] act, input logic [519:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Queue one message on the source side; when it is a store, also queue what memory and the ack path must see.
    task automatic post_write(input logic [47:0] addr, input logic [15:0] size, input int len,
                              input logic [13:0] chip, input logic [7:0] x, input logic [7:0] y,
                              input logic [3:0] f, input logic [7:0] mtype, input bit exp_store,
                              input int send_flits);
        hdr_t          h;
        hdr_t          a;
        src_t          s;
        flit_t         fl;
        mem_req_struct r;
        h = '0;
        h.dst_x = TB_X; h.dst_y = TB_Y; h.dst_fbits = TB_F;
        h.msg_len = len[7:0]; h.msg_type = mtype;
        h.src_chip = chip; h.src_x = x; h.src_y = y; h.src_fbits = f;
        h.addr = addr; h.data_size = size;
        s.dat = h; s.is_hdr = 1'b1;
        src_q.push_back(s);
        for (int i = 0; i < send_flits; i++) begin
            for (int w = 0; w < 16; w++) s.dat[w*32 +: 32] = $urandom();
            s.is_hdr = 1'b0;
            src_q.push_back(s);
            if (exp_store) begin
                fl.dat  = s.dat;
                fl.last = (i == len - 1);
                fl.pad  = fl.last ? 6'(((len * 64 - int'(size)) % 64 + 64) % 64) : 6'd0;
                exp_flit_q.push_back(fl);
            end
        end
        if (exp_store) begin
            r.addr = addr; r.size = size;
            exp_req_q.push_back(r);
            exp_len_q.push_back(len);
            a = '0;
            a.dst_chip = chip; a.dst_x = x; a.dst_y = y; a.dst_fbits = f;
            a.msg_type = MSG_TYPE_STORE_MEM_ACK;
            a.src_x = TB_X; a.src_y = TB_Y; a.src_fbits = TB_F;
            exp_ack_q.push_back(a);
        end
    endtask

    task automatic env_clear();
        src_q.delete(); exp_req_q.delete(); exp_flit_q.delete(); exp_ack_q.delete(); exp_len_q.delete();
        in_wr = 0; seen = 0; cur_len = 0; done_cnt = -1; done_given = 0;
    endtask

    task automatic wait_acks(input int target, input int budget);
        int n = 0;
        while (acks < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("ack_timeout", acks >= target, 1);
    endtask

    // Environment: monitors handshakes on the falling edge, drives source/memory/ack-sink just after the rising edge.
    initial begin : env
        flit_t         fl;
        mem_req_struct r;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (noc0_wr_tgt_req_val && wr_tgt_noc0_req_rdy && src_q.size() > 0) begin
                    if (src_q[0].is_hdr) begin
                        if (last_ack_cyc != 0) check("hdr_bubble", cyc != last_ack_cyc, 1);
                        hdr_cyc = cyc;
                    end
                    void'(src_q.pop_front());
                end
                if (wr_tgt_mem_req_val && mem_wr_tgt_req_rdy) begin
                    reqs++;
                    check("mem_req_expected", exp_req_q.size() != 0, 1);
                    if (exp_req_q.size() != 0) begin
                        r = exp_req_q.pop_front();
                        check("mem_req", wr_tgt_mem_req_entry, r);
                        cur_len = exp_len_q.pop_front();
                    end
                    in_wr = 1; seen = 0;
                    if (cur_len == 0) done_cnt = $urandom_range(done_max, 0);
                end
                if (wr_tgt_mem_data_val && mem_wr_tgt_data_rdy) begin
                    flits++;
                    if (wr_tgt_mem_data_last) begin
                        lasts++;
                        last_pad = wr_tgt_mem_data_padbytes;
                    end
                    check("mem_data_expected", exp_flit_q.size() != 0, 1);
                    if (exp_flit_q.size() != 0) begin
                        fl = exp_flit_q.pop_front();
                        check("mem_data", {wr_tgt_mem_data, wr_tgt_mem_data_last, wr_tgt_mem_data_padbytes}, fl);
                    end
                    seen++;
                    if (in_wr && seen == cur_len) done_cnt = $urandom_range(done_max, 0);
                end
                if (wr_tgt_noc0_resp_val && noc0_wr_tgt_resp_rdy) begin
                    acks++;
                    last_ack = wr_tgt_noc0_resp_data;
                    last_ack_cyc = cyc;
                    last_lat = cyc - hdr_cyc;
                    check("ack_after_done", done_given, 1);
                    check("ack_expected", exp_ack_q.size() != 0, 1);
                    if (exp_ack_q.size() != 0) check("ack", wr_tgt_noc0_resp_data, exp_ack_q.pop_front());
                    done_given = 0; in_wr = 0;
                end
            end
            @(posedge clk);
            #1;
            if (src_q.size() > 0 && (bp == 0 || $urandom_range(3, 0) != 0)) begin
                noc0_wr_tgt_req_val  = 1'b1;
                noc0_wr_tgt_req_data = src_q[0].dat;
            end else begin
                noc0_wr_tgt_req_val  = 1'b0;
                noc0_wr_tgt_req_data = '0;
            end
            mem_wr_tgt_req_rdy   = (bp == 0) ? 1'b1 : 1'($urandom_range(1, 0));
            mem_wr_tgt_data_rdy  = (bp == 0) ? 1'b1 : 1'($urandom_range(1, 0));
            noc0_wr_tgt_resp_rdy = (bp == 0) ? 1'b1 : 1'($urandom_range(1, 0));
            mem_wr_tgt_done = 1'b0;
            if (done_cnt == 0) begin
                mem_wr_tgt_done = 1'b1;
                done_given = 1;
                done_cnt = -1;
            end else if (done_cnt > 0) begin
                done_cnt--;
            end else if (spur != 0 && !(in_wr && seen == cur_len) && $urandom_range(9, 0) == 0) begin
                mem_wr_tgt_done = 1'b1;
            end
        end
    end

    typedef struct {
        logic [47:0] addr;
        logic [15:0] size;
        int          len;
        logic [7:0]  sx;
        logic [7:0]  sy;
        int          exp_flits;
        int          exp_lasts;
        logic [5:0]  exp_pad;
        int          exp_lat;
    } vec_t;

    initial begin : main
        vec_t vt[4];
        hdr_t ah;
        int   a0, f0, r0, l0, n;

        vt[0] = '{48'h1000, 16'd128, 2, 8'd3, 8'd1, 2, 1, 6'd0,  5};
        vt[1] = '{48'h2000, 16'd100, 2, 8'd3, 8'd1, 2, 1, 6'd28, 5};
        vt[2] = '{48'h3000, 16'd0,   0, 8'd7, 8'd2, 0, 0, 6'd0,  3};
        vt[3] = '{48'h0040, 16'd1,   1, 8'd0, 8'd9, 1, 1, 6'd63, 4};

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_req_rdy", wr_tgt_noc0_req_rdy, 0);
        check("rst_mem_req_val", wr_tgt_mem_req_val, 0);
        check("rst_mem_data_val", wr_tgt_mem_data_val, 0);
        check("rst_resp_val", wr_tgt_noc0_resp_val, 0);
        check("rst_err", wr_tgt_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("idle_req_rdy", wr_tgt_noc0_req_rdy, 1);

        // Directed table: no backpressure, memory answers done immediately.
        for (int i = 0; i < 4; i++) begin
            flits = 0; lasts = 0;
            post_write(vt[i].addr, vt[i].size, vt[i].len, 14'd0, vt[i].sx, vt[i].sy, 4'd1,
                       MSG_TYPE_STORE_MEM, 1, vt[i].len);
            wait_acks(acks + 1, 600);
            check($sformatf("vec%0d_flits", i), flits, vt[i].exp_flits);
            check($sformatf("vec%0d_lasts", i), lasts, vt[i].exp_lasts);
            if (vt[i].exp_lasts != 0) check($sformatf("vec%0d_pad", i), last_pad, vt[i].exp_pad);
            check($sformatf("vec%0d_latency", i), last_lat, vt[i].exp_lat);
            ah = hdr_t'(last_ack);
            check($sformatf("vec%0d_ack_dst_x", i), ah.dst_x, vt[i].sx);
            check($sformatf("vec%0d_ack_dst_y", i), ah.dst_y, vt[i].sy);
        end

        // Maximum msg_len: the counter must reach the last flit without wrapping.
        flits = 0; lasts = 0;
        post_write(48'h8000, 16'd16315, 255, 14'd3, 8'd2, 8'd4, 4'd0, MSG_TYPE_STORE_MEM, 1, 255);
        wait_acks(acks + 1, 2000);
        check("maxlen_flits", flits, 255);
        check("maxlen_lasts", lasts, 1);
        check("maxlen_pad", last_pad, 6'd5);
        check("maxlen_latency", last_lat, 258);

        // Non-store message type, followed by a regular store.
        a0 = acks; f0 = flits; r0 = reqs;
`ifdef NOC_WR_TGT_TYPE_CHECK_EN
        post_write(48'h9000, 16'd192, 3, 14'd1, 8'd1, 8'd1, 4'd0, MSG_TYPE_LOAD_MEM, 0, 3);
        post_write(48'h9100, 16'd64, 1, 14'd1, 8'd1, 8'd1, 4'd0, MSG_TYPE_STORE_MEM, 1, 1);
        wait_acks(a0 + 1, 600);
        repeat (5) @(negedge clk);
        check("drain_acks", acks - a0, 1);
        check("drain_reqs", reqs - r0, 1);
        check("drain_flits", flits - f0, 1);
        check("drain_err_sticky", wr_tgt_err, 1);
`else
        post_write(48'h9000, 16'd192, 3, 14'd1, 8'd1, 8'd1, 4'd0, MSG_TYPE_LOAD_MEM, 1, 3);
        wait_acks(a0 + 1, 600);
        check("notype_acks", acks - a0, 1);
        check("notype_reqs", reqs - r0, 1);
        check("notype_flits", flits - f0, 3);
        check("notype_err", wr_tgt_err, 0);
`endif

        // Randomized traffic with 50% backpressure, variable memory latency and stray done pulses.
        bp = 1; done_max = 3; spur = 1;
        a0 = acks;
        for (int i = 0; i < 100; i++) begin
            l0 = $urandom_range(6, 0);
            post_write({16'h0, $urandom()}, 16'($urandom_range(l0 * 64, 0)), l0,
                       14'($urandom()), 8'($urandom()), 8'($urandom()), 4'($urandom()),
                       MSG_TYPE_STORE_MEM, 1, l0);
        end
        wait_acks(a0 + 100, 20000);
        repeat (10) @(negedge clk);
        check("rand_ack_count", acks - a0, 100);
        check("rand_req_left", exp_req_q.size(), 0);
        check("rand_flit_left", exp_flit_q.size(), 0);
        check("rand_src_left", src_q.size(), 0);
        bp = 0; done_max = 0; spur = 0;

        // Reset in the middle of a 4-flit payload after one flit has gone through.
        f0 = flits;
        post_write(48'hA000, 16'd256, 4, 14'd2, 8'd8, 8'd8, 4'd0, MSG_TYPE_STORE_MEM, 1, 1);
        n = 0;
        while (flits - f0 < 1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("midrst_first_flit", flits - f0, 1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_req_rdy", wr_tgt_noc0_req_rdy, 0);
        check("midrst_mem_req_val", wr_tgt_mem_req_val, 0);
        check("midrst_mem_data_val", wr_tgt_mem_data_val, 0);
        check("midrst_resp_val", wr_tgt_noc0_resp_val, 0);
        check("midrst_err", wr_tgt_err, 0);
        env_clear();
        a0 = acks;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check("midrst_idle_rdy", wr_tgt_noc0_req_rdy, 1);
        flits = 0; lasts = 0;
        post_write(48'hB000, 16'd120, 2, 14'd0, 8'd4, 8'd3, 4'd1, MSG_TYPE_STORE_MEM, 1, 2);
        wait_acks(a0 + 1, 600);
        check("postrst_flits", flits, 2);
        check("postrst_lasts", lasts, 1);
        check("postrst_pad", last_pad, 6'd8);
        check("postrst_latency", last_lat, 5);
        check("postrst_acks", acks - a0, 1);
        check("final_err", wr_tgt_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
